// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day counter advanced by a 1 Hz enable, with a
// RUN -> SET_HR -> SET_MIN set-mode FSM and a day-rollover pulse.
module time_keeper #(
  parameter int unsigned INIT_HR  = 12,
  parameter int unsigned INIT_MIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic [1:0] state,
  output logic       blink,
  output logic       day_pulse
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FIELD_W = 2 * DIGIT_W;

  localparam logic [FIELD_W-1:0] RST_HR  = {DIGIT_W'(INIT_HR / 10),  DIGIT_W'(INIT_HR % 10)};
  localparam logic [FIELD_W-1:0] RST_MIN = {DIGIT_W'(INIT_MIN / 10), DIGIT_W'(INIT_MIN % 10)};

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t             r_state;
  logic [FIELD_W-1:0] r_sec;
  logic [FIELD_W-1:0] r_min;
  logic [FIELD_W-1:0] r_hr;
  logic               r_blink;
  logic               r_day_pulse;

  logic               w_sec_max;
  logic               w_min_max;
  logic               w_hr_max;
  logic [FIELD_W-1:0] w_sec_inc;
  logic [FIELD_W-1:0] w_min_inc;
  logic [FIELD_W-1:0] w_hr_inc;

  // Two-digit BCD increment: ones wrap into tens; caller handles the field limit.
  function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v);
    if (v[DIGIT_W-1:0] == DIGIT_W'(9))
      bcd_inc = {v[FIELD_W-1:DIGIT_W] + DIGIT_W'(1), DIGIT_W'(0)};
    else
      bcd_inc = {v[FIELD_W-1:DIGIT_W], v[DIGIT_W-1:0] + DIGIT_W'(1)};
  endfunction

  assign w_sec_max = (r_sec == 8'h59);
  assign w_min_max = (r_min == 8'h59);
  assign w_hr_max  = (r_hr  == 8'h23);
  assign w_sec_inc = w_sec_max ? '0 : bcd_inc(r_sec);
  assign w_min_inc = w_min_max ? '0 : bcd_inc(r_min);
  assign w_hr_inc  = w_hr_max  ? '0 : bcd_inc(r_hr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_sec       <= '0;
      r_min       <= RST_MIN;
      r_hr        <= RST_HR;
      r_blink     <= 1'b1;
      r_day_pulse <= 1'b0;
    end else begin
      r_day_pulse <= 1'b0;
      case (r_state)
        RUN: begin
          r_blink <= 1'b1;
          if (mode_p) begin
            r_state <= SET_HR;
            r_sec   <= '0;
          end else if (tick) begin
            // Full ripple resolved in a single cycle.
            r_sec <= w_sec_inc;
            if (w_sec_max) begin
              r_min <= w_min_inc;
              if (w_min_max) begin
                r_hr <= w_hr_inc;
                if (w_hr_max) r_day_pulse <= 1'b1;
              end
            end
          end
        end
        SET_HR: begin
          if (mode_p) begin
            r_state <= SET_MIN;
            r_blink <= 1'b1;
          end else begin
            if (inc_p) r_hr <= w_hr_inc;
            if (tick)  r_blink <= ~r_blink;
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            r_state <= RUN;
            r_blink <= 1'b1;
          end else begin
            if (inc_p) r_min <= w_min_inc;
            if (tick)  r_blink <= ~r_blink;
          end
        end
        default: begin
          r_state <= RUN;
          r_blink <= 1'b1;
        end
      endcase
    end
  end

  assign sec_ones  = r_sec[DIGIT_W-1:0];
  assign sec_tens  = r_sec[FIELD_W-1:DIGIT_W];
  assign min_ones  = r_min[DIGIT_W-1:0];
  assign min_tens  = r_min[FIELD_W-1:DIGIT_W];
  assign hr_ones   = r_hr[DIGIT_W-1:0];
  assign hr_tens   = r_hr[FIELD_W-1:DIGIT_W];
  assign state     = r_state;
  assign blink     = r_blink;
  assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios followed by random
// stimulus, all compared against a seconds-of-day reference model.
module tb_time_keeper;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       mode_p;
  logic       inc_p;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [3:0] hr_ones;
  logic [3:0] hr_tens;
  logic [1:0] state;
  logic       blink;
  logic       day_pulse;

  int n_checks;
  int n_fails;

  // Reference model: plain integers, mode 0=RUN 1=SET_HR 2=SET_MIN.
  int m_hh, m_mm, m_ss, m_mode, m_blink, m_day;

  time_keeper #(.INIT_HR(12), .INIT_MIN(0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_p(mode_p), .inc_p(inc_p),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .state(state), .blink(blink), .day_pulse(day_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit t, input bit m, input bit i, input bit r);
    int total;
    if (r) begin
      m_hh = 12; m_mm = 0; m_ss = 0; m_mode = 0; m_blink = 1; m_day = 0;
      return;
    end
    m_day = 0;
    case (m_mode)
      0: begin
        m_blink = 1;
        if (m) begin
          m_mode = 1; m_ss = 0;
        end else if (t) begin
          total = m_hh * 3600 + m_mm * 60 + m_ss + 1;
          if (total == 86400) begin
            total = 0; m_day = 1;
          end
          m_hh = total / 3600;
          m_mm = (total / 60) % 60;
          m_ss = total % 60;
        end
      end
      1: begin
        if (m) begin
          m_mode = 2; m_blink = 1;
        end else begin
          if (i) m_hh = (m_hh + 1) % 24;
          if (t) m_blink = 1 - m_blink;
        end
      end
      default: begin
        if (m) begin
          m_mode = 0; m_blink = 1;
        end else begin
          if (i) m_mm = (m_mm + 1) % 60;
          if (t) m_blink = 1 - m_blink;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check("sec_ones",  32'(sec_ones),  32'(m_ss % 10));
    check("sec_tens",  32'(sec_tens),  32'(m_ss / 10));
    check("min_ones",  32'(min_ones),  32'(m_mm % 10));
    check("min_tens",  32'(min_tens),  32'(m_mm / 10));
    check("hr_ones",   32'(hr_ones),   32'(m_hh % 10));
    check("hr_tens",   32'(hr_tens),   32'(m_hh / 10));
    check("state",     32'(state),     32'(m_mode));
    check("blink",     32'(blink),     32'(m_blink));
    check("day_pulse", 32'(day_pulse), 32'(m_day));
  endtask

  task automatic cycle(input bit t, input bit m, input bit i, input bit r);
    @(negedge clk);
    tick = t; mode_p = m; inc_p = i; rst = r;
    @(posedge clk);
    model_step(t, m, i, r);
    #1;
    check_all();
  endtask

  task automatic repeat_cycle(input int n, input bit t, input bit m, input bit i);
    for (int k = 0; k < n; k++) cycle(t, m, i, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    rst = 1'b1; tick = 1'b0; mode_p = 1'b0; inc_p = 1'b0;
    m_hh = 12; m_mm = 0; m_ss = 0; m_mode = 0; m_blink = 1; m_day = 0;

    // Reset to defaults.
    cycle(0, 0, 0, 1);
    check("rst_time", 32'({hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}), 32'h120000);
    cycle(0, 0, 0, 0);

    // 12 -> 00 hours, back to RUN, count up to 00:00:59 then one more tick.
    cycle(0, 1, 0, 0);
    repeat_cycle(12, 0, 0, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    repeat_cycle(59, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("sec59_carry", 32'({hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}), 32'h000100);

    // Set 23:59, run 60 ticks to midnight rollover.
    cycle(0, 1, 0, 0);
    repeat_cycle(23, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat_cycle(58, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat_cycle(59, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("rollover_day", 32'(day_pulse), 32'd1);
    check("rollover_time", 32'({hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}), 32'h000000);
    cycle(0, 0, 0, 0);
    check("day_pulse_once", 32'(day_pulse), 32'd0);

    // Build 10:20:35 in RUN.
    cycle(0, 1, 0, 0);
    repeat_cycle(10, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat_cycle(20, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat_cycle(35, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("enter_set_hr", 32'({state, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}), 32'h1102000);
    for (int k = 0; k < 14; k++) cycle(k[0], 0, 1, 0);
    repeat_cycle(3, 1, 0, 0);
    check("hr_wrap_24", 32'({hr_tens, hr_ones}), 32'h00);

    // mode+inc together: transition wins, hours untouched.
    cycle(0, 1, 1, 0);
    check("mode_inc_state", 32'(state), 32'd2);
    repeat_cycle(39, 0, 0, 1);
    cycle(1, 0, 1, 0);
    check("min_wrap_60", 32'({hr_tens, hr_ones, min_tens, min_ones}), 32'h0000);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("first_tick", 32'({sec_tens, sec_ones}), 32'h01);

    // tick+mode at ss=30: no carry, seconds cleared.
    repeat_cycle(29, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("tick_mode_run", 32'({state, sec_tens, sec_ones}), 32'h100);

    // Reset during SET_MIN.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("rst_mid_set", 32'({state, hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}), 32'h0120000);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 1) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
